// File: rtl/pmp_scan_checker_pkg.sv
// pmp_scan_checker_pkg: shared PMP address-mode, access-type, privilege and scan-state definitions
package pmp_scan_checker_pkg;
  typedef enum logic [1:0] {OFF, TOR, NA4, NAPOT} pmp_a_t;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} scan_state_t;
  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;
  localparam logic [1:0] PRIV_M = 2'b11;
endpackage

// File: rtl/pmp_scan_checker_entry_match.sv
// pmp_scan_checker_entry_match: one PMP entry range test on first/last byte (i_pa, i_last_pa, i_addr, i_prev_addr, i_cfg, i_type, i_priv -> o_full, o_partial, o_perm_ok)
module pmp_scan_checker_entry_match
  import pmp_scan_checker_pkg::*;
#(
  parameter int PA_BITS = 56,
  parameter int PMP_G = 0
) (
  input  logic [PA_BITS-1:0] i_pa,
  input  logic [PA_BITS-1:0] i_last_pa,
  input  logic [PA_BITS-3:0] i_addr,
  input  logic [PA_BITS-3:0] i_prev_addr,
  input  logic [7:0]         i_cfg,
  input  logic [2:0]         i_type,
  input  logic [1:0]         i_priv,
  output logic               o_full,
  output logic               o_partial,
  output logic               o_perm_ok
);
  localparam logic [PA_BITS-3:0] ONE = 1;
  pmp_a_t w_a;
  logic [PA_BITS-3:0] w_t;
  logic w_in_pa, w_in_last, w_unused;
  assign w_a = pmp_a_t'(i_cfg[4:3]);
  assign w_t = i_addr ^ (i_addr + ONE);
  assign w_unused = ^i_cfg[6:5];
  function automatic logic f_in(input logic [PA_BITS-1:0] a);
    logic [PA_BITS-3:0] w;
    w = a[PA_BITS-1:2];
    return w_a == TOR ? (a >= {i_prev_addr, 2'b00} && a < {i_addr, 2'b00}) :
           w_a == NA4 ? (PMP_G == 0 && w == i_addr) :
           w_a == NAPOT ? (((w ^ i_addr) & ~w_t) == '0) : 1'b0;
  endfunction
  assign w_in_pa = f_in(i_pa);
  assign w_in_last = f_in(i_last_pa);
  assign o_full = w_in_pa & w_in_last;
  assign o_partial = w_in_pa ^ w_in_last;
  // An unlocked entry grants M-mode everything; otherwise the type bit must be enabled.
  assign o_perm_ok = (|(i_type & i_cfg[2:0])) | (~i_cfg[7] & (i_priv == PRIV_M));
endmodule

// File: rtl/pmp_scan_checker.sv
// pmp_scan_checker: multi-cycle PMP checker scanning ENTRIES_PER_CYCLE entries per clock (Req* in, Rsp* out, live PMPADDR/PMPCFG arrays, Flush abort)
module pmp_scan_checker
  import pmp_scan_checker_pkg::*;
#(
  parameter int PA_BITS = 56,
  parameter int PMP_ENTRIES = 16,
  parameter int PMP_G = 0,
  parameter int ENTRIES_PER_CYCLE = 4,
  localparam int N1 = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [PA_BITS-1:0] ReqPA,
  input  logic [1:0]         ReqSize,
  input  logic [2:0]         ReqType,
  input  logic [1:0]         ReqPriv,
  input  logic               Flush,
  input  logic [PA_BITS-3:0] PMPADDR_ARRAY_REGW [N1],
  input  logic [7:0]         PMPCFG_ARRAY_REGW [N1],
  output logic               RspValid,
  input  logic               RspReady,
  output logic               RspFault,
  output logic               RspHit,
  output logic [5:0]         RspIdx
);
  localparam int EPC = ENTRIES_PER_CYCLE;
  localparam int NG = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES / EPC;
  localparam int NP = NG * EPC;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int EW = (EPC > 1) ? $clog2(EPC) : 1;
  localparam int W1 = PA_BITS + 1;
  scan_state_t r_state, w_next;
  logic [PA_BITS-1:0] r_pa, r_last;
  logic r_carry, r_fault, r_hit;
  logic [2:0] r_type;
  logic [1:0] r_priv;
  logic [5:0] r_idx, w_idx;
  logic [GW-1:0] r_grp;
  logic [W1-1:0] w_last;
  logic [PA_BITS-3:0] w_ext [NP+1];
  logic [7:0] w_cfg_all [NP];
  logic [PA_BITS-3:0] w_top [EPC];
  logic [PA_BITS-3:0] w_prev [EPC];
  logic [7:0] w_gcfg [EPC];
  logic [EPC-1:0] w_full, w_part, w_perm;
  logic [EW-1:0] w_sel;
  logic w_any, w_accept, w_resolve;
  // w_ext[k] is the top of entry k-1, so w_ext[0] doubles as the TOR base of entry 0.
  assign w_ext[0] = '0;
  for (genvar i = 0; i < NP; i++) begin : g_pad
    if (i < PMP_ENTRIES) begin : g_on
      assign w_ext[i+1] = PMPADDR_ARRAY_REGW[i];
      assign w_cfg_all[i] = PMPCFG_ARRAY_REGW[i];
    end else begin : g_off
      assign w_ext[i+1] = '0;
      assign w_cfg_all[i] = '0;
    end
  end
  always_comb begin
    for (int j = 0; j < EPC; j++) begin
      w_top[j] = '0;
      w_prev[j] = '0;
      w_gcfg[j] = '0;
    end
    for (int g = 0; g < NG; g++)
      if (r_grp == GW'(g))
        for (int j = 0; j < EPC; j++) begin
          w_top[j] = w_ext[g*EPC+j+1];
          w_prev[j] = w_ext[g*EPC+j];
          w_gcfg[j] = w_cfg_all[g*EPC+j];
        end
  end
  for (genvar j = 0; j < EPC; j++) begin : g_match
    pmp_scan_checker_entry_match #(.PA_BITS(PA_BITS), .PMP_G(PMP_G)) u_match (
      .i_pa(r_pa), .i_last_pa(r_last), .i_addr(w_top[j]), .i_prev_addr(w_prev[j]),
      .i_cfg(w_gcfg[j]), .i_type(r_type), .i_priv(r_priv),
      .o_full(w_full[j]), .o_partial(w_part[j]), .o_perm_ok(w_perm[j])
    );
  end
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int j = EPC - 1; j >= 0; j--)
      if (w_full[j] | w_part[j]) begin
        w_any = 1'b1;
        w_sel = EW'(j);
      end
  end
  assign w_idx = 6'(int'(r_grp) * EPC + int'(w_sel));
  assign w_last = ({1'b0, ReqPA} + (W1'(1) << ReqSize)) - W1'(1);
  assign ReqReady = (r_state == IDLE) & ~reset;
  assign RspValid = r_state == RESP;
  assign RspFault = r_fault;
  assign RspHit = r_hit;
  assign RspIdx = r_idx;
  assign w_accept = (r_state == IDLE) & ReqValid & ~Flush;
  assign w_resolve = (r_state == SCAN) & (r_carry | w_any | (r_grp == GW'(NG - 1)));
  always_comb begin
    w_next = (Flush && r_state != IDLE) ? IDLE :
             r_state == IDLE ? (w_accept ? (PMP_ENTRIES == 0 ? RESP : SCAN) : IDLE) :
             r_state == SCAN ? (w_resolve ? RESP : SCAN) :
             RspReady ? IDLE : RESP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
      r_hit <= 1'b0;
      r_idx <= '0;
      r_grp <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pa <= ReqPA;
        r_last <= w_last[PA_BITS-1:0];
        r_carry <= w_last[PA_BITS];
        r_type <= ReqType;
        r_priv <= ReqPriv;
        r_grp <= '0;
        if (PMP_ENTRIES == 0) begin
          r_fault <= w_last[PA_BITS];
          r_hit <= 1'b0;
          r_idx <= '0;
        end
      end else if (r_state == SCAN && !Flush) begin
        if (w_resolve) begin
          r_hit <= ~r_carry & w_any;
          r_idx <= (~r_carry & w_any) ? w_idx : '0;
          r_fault <= r_carry | (w_any ? (w_part[w_sel] | ~w_perm[w_sel]) : (r_priv != PRIV_M));
        end else begin
          r_grp <= r_grp + GW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pmp_scan_checker.sv
// tb_pmp_scan_checker: directed self-checking bench for pmp_scan_checker (16 entries, 4 per cycle, PA_BITS=56)
module tb_pmp_scan_checker;
  import pmp_scan_checker_pkg::*;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_fault, rsp_hit;
  logic [55:0] req_pa;
  logic [1:0] req_size, req_priv;
  logic [2:0] req_type;
  logic [5:0] rsp_idx;
  logic [53:0] pmp_addr [16];
  logic [7:0] pmp_cfg [16];
  int nerr = 0;
  int nchk = 0;
  int lat;
  always #5 clk = ~clk;
  pmp_scan_checker dut (
    .clk(clk), .reset(reset), .ReqValid(req_valid), .ReqReady(req_ready), .ReqPA(req_pa),
    .ReqSize(req_size), .ReqType(req_type), .ReqPriv(req_priv), .Flush(flush),
    .PMPADDR_ARRAY_REGW(pmp_addr), .PMPCFG_ARRAY_REGW(pmp_cfg), .RspValid(rsp_valid),
    .RspReady(rsp_ready), .RspFault(rsp_fault), .RspHit(rsp_hit), .RspIdx(rsp_idx)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_pmp();
    for (int i = 0; i < 16; i++) begin
      pmp_addr[i] = '0;
      pmp_cfg[i] = '0;
    end
  endtask
  task automatic req(input logic [55:0] pa, input logic [1:0] sz, input logic [2:0] ty, input logic [1:0] pv);
    @(negedge clk);
    req_pa = pa;
    req_size = sz;
    req_type = ty;
    req_priv = pv;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic rsp(input string tag, input int exp_lat, input logic f, input logic h, input logic [5:0] idx);
    chk({tag, " valid"}, 64'(rsp_valid), 64'(1));
    if (exp_lat > 0) chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " fault"}, 64'(rsp_fault), 64'(f));
    chk({tag, " hit"}, 64'(rsp_hit), 64'(h));
    chk({tag, " idx"}, 64'(rsp_idx), 64'(idx));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " ready after consume"}, 64'(req_ready), 64'(1));
  endtask
  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    req_pa = '0;
    req_size = '0;
    req_type = '0;
    req_priv = '0;
    clear_pmp();
    repeat (3) @(negedge clk);
    chk("reset ReqReady", 64'(req_ready), 64'(0));
    chk("reset RspValid", 64'(rsp_valid), 64'(0));
    chk("reset fields", {61'(0), rsp_fault, rsp_hit, 1'b0} | 64'(rsp_idx), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle ReqReady", 64'(req_ready), 64'(1));
    req(56'h8000_0000, 2'd2, ACC_R, 2'b01);
    rsp("S read no entries", 5, 1'b1, 1'b0, 6'd0);
    req(56'h8000_0000, 2'd2, ACC_R, 2'b11);
    rsp("M read no entries", 5, 1'b0, 1'b0, 6'd0);
    pmp_addr[3] = 54'h2000_01FF;
    pmp_cfg[3] = 8'h1B;
    req(56'h8000_0FF8, 2'd3, ACC_R, 2'b00);
    rsp("U read napot", 2, 1'b0, 1'b1, 6'd3);
    req(56'h8000_0FF8, 2'd3, ACC_X, 2'b00);
    rsp("U exec napot", 2, 1'b1, 1'b1, 6'd3);
    req(56'h8000_0FFC, 2'd3, ACC_R, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("hold RspValid", 64'(rsp_valid), 64'(1));
      chk("hold RspIdx", 64'(rsp_idx), 64'(3));
      chk("hold RspFault", 64'(rsp_fault), 64'(1));
      chk("hold ReqReady", 64'(req_ready), 64'(0));
    end
    rsp("U read straddle", 2, 1'b1, 1'b1, 6'd3);
    clear_pmp();
    pmp_addr[0] = 54'h400;
    pmp_cfg[0] = 8'h09;
    pmp_addr[5] = 54'h1FF;
    pmp_cfg[5] = 8'h1F;
    req(56'h800, 2'd2, ACC_W, 2'b00);
    rsp("U write tor ronly", 2, 1'b1, 1'b1, 6'd0);
    req(56'h800, 2'd2, ACC_W, 2'b11);
    rsp("M write unlocked", 2, 1'b0, 1'b1, 6'd0);
    pmp_cfg[0] = 8'h89;
    req(56'h800, 2'd2, ACC_W, 2'b11);
    rsp("M write locked", 2, 1'b1, 1'b1, 6'd0);
    pmp_cfg[0] = 8'h00;
    req(56'h800, 2'd2, ACC_W, 2'b00);
    rsp("U write entry5", 3, 1'b0, 1'b1, 6'd5);
    req(56'h1000, 2'd0, ACC_R, 2'b00);
    rsp("U read beyond napot", 5, 1'b1, 1'b0, 6'd0);
    req(56'h800, 2'd2, ACC_W, 2'b00);
    rsp("U write entry5 again", 3, 1'b0, 1'b1, 6'd5);
    clear_pmp();
    @(negedge clk);
    req_pa = 56'h8000_0000;
    req_size = 2'd2;
    req_type = ACC_R;
    req_priv = 2'b00;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset RspValid", 64'(rsp_valid), 64'(0));
    chk("mid reset ReqReady", 64'(req_ready), 64'(0));
    chk("mid reset RspHit", 64'(rsp_hit), 64'(0));
    chk("mid reset RspIdx", 64'(rsp_idx), 64'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("after reset no rsp", 64'(rsp_valid), 64'(0));
    chk("after reset ReqReady", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush RspValid", 64'(rsp_valid), 64'(0));
    chk("flush ReqReady", 64'(req_ready), 64'(1));
    repeat (6) @(negedge clk);
    chk("flush no late rsp", 64'(rsp_valid), 64'(0));
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush blocks accept", 64'(req_ready), 64'(1));
    repeat (6) @(negedge clk);
    chk("idle flush no rsp", 64'(rsp_valid), 64'(0));
    req(56'hFF_FFFF_FFFF_FFFC, 2'd3, ACC_R, 2'b11);
    rsp("M read wrap", 0, 1'b1, 1'b0, 6'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
